spmp_csr_regs: RTL and testbench

- Architectural state holder for S-mode Physical Memory Protection (SPMP): spmpcfg, spmpaddr and spmpswitch.
- Sits directly upstream of the SPMP permission checker and drives its cfg/addr/switch inputs.
- Serves CSR-file read/write requests over a valid/ready handshake and applies WARL legalization.
- After any effective change, requests a flush of in-flight memory accesses and holds the write response until the flush is acknowledged.

---
 rtl/spmp_csr_regs_pkg.sv | 64 ++++++
 rtl/spmp_csr_regs_if.sv | 35 +++
 rtl/spmp_csr_regs_cfg_legalizer.sv | 18 +
 rtl/spmp_csr_regs.sv | 206 ++++++++++++++++++++
 tb/tb_spmp_csr_regs.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmp_csr_regs_pkg.sv
// ----------------------------------------------------------------------------
// spmp_csr_regs_pkg
// Shared types and helpers for the S-mode PMP CSR register block.
//   spmp_sel_e        : which CSR group a request addresses (CFG/ADDR/SWITCH)
//   spmpcfg_t         : one per-entry configuration byte
//   spmp_state_e      : request-handling FSM states
//   legalize_spmpcfg  : WARL rule for a single cfg byte
//   switch_mask       : mask of implemented entries for spmpswitch
// ----------------------------------------------------------------------------
package spmp_csr_regs_pkg;

   localparam int unsigned XLEN = 64;

   typedef enum logic [1:0] {
      SPMP_SEL_CFG    = 2'd0,
      SPMP_SEL_ADDR   = 2'd1,
      SPMP_SEL_SWITCH = 2'd2,
      SPMP_SEL_RSVD   = 2'd3
   } spmp_sel_e;

   // Byte layout of a cfg entry: [7]S [6:5]reserved [4:3]A [2]X [1]W [0]R
   typedef struct packed {
      logic       s_mode;
      logic [1:0] reserved;
      logic [1:0] addr_mode;
      logic [2:0] access_perm;
   } spmpcfg_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RESP  = 2'd2
   } spmp_state_e;

   localparam int unsigned CfgRBit = 0;
   localparam int unsigned CfgWBit = 1;
   localparam int unsigned CfgXBit = 2;
   localparam int unsigned CfgSBit = 7;
   localparam logic [7:0]  CfgRsvdMask = 8'h60;

   // Reserved encodings (W without R, or S with no permissions) leave the
   // entry untouched; otherwise the new byte is taken with reserved bits cleared.
   function automatic logic [7:0] legalize_spmpcfg(input logic [7:0] old_byte,
                                                   input logic [7:0] new_byte);
      logic [7:0] result;
      result = new_byte & ~CfgRsvdMask;
      if (new_byte[CfgWBit] && !new_byte[CfgRBit]) begin
         result = old_byte;
      end else if (new_byte[CfgSBit] && (new_byte[CfgXBit:CfgRBit] == 3'b000)) begin
         result = old_byte;
      end
      return result;
   endfunction

   // One bit per implemented entry, upper bits zero.
   function automatic logic [XLEN-1:0] switch_mask(input int unsigned nr_entries);
      logic [XLEN-1:0] mask;
      for (int i = 0; i < XLEN; i++) begin
         mask[i] = (i < nr_entries);
      end
      return mask;
   endfunction

endpackage

// File: rtl/spmp_csr_regs_if.sv
// ----------------------------------------------------------------------------
// spmp_csr_regs_if
// CSR request/response channel between the CSR file (master) and the SPMP
// register block (slave).
//   req_valid/req_ready : request handshake, transfer when both high
//   req_we              : 1 = write, 0 = read
//   req_sel/req_idx     : target group and cfg word / addr entry number
//   req_wdata           : write data
//   rsp_valid           : single-cycle response strobe, no backpressure
//   rsp_rdata/rsp_err   : read data (post-legalization for writes), error flag
// ----------------------------------------------------------------------------
interface spmp_csr_regs_if;
   import spmp_csr_regs_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   spmp_sel_e       req_sel;
   logic [5:0]      req_idx;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_sel, req_idx, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_sel, req_idx, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/spmp_csr_regs_cfg_legalizer.sv
// ----------------------------------------------------------------------------
// spmp_cfg_legalizer
// Combinational WARL legalization of one spmpcfg byte.
//   old_byte   : currently stored (already legal) byte
//   new_byte   : byte lane taken from the write data
//   legal_byte : value that would be stored on commit
// ----------------------------------------------------------------------------
module spmp_cfg_legalizer
   import spmp_csr_regs_pkg::*;
(
   input  logic [7:0] old_byte,
   input  logic [7:0] new_byte,
   output logic [7:0] legal_byte
);

   assign legal_byte = legalize_spmpcfg(old_byte, new_byte);

endmodule

// File: rtl/spmp_csr_regs.sv
// ----------------------------------------------------------------------------
// spmp_csr_regs
// Architectural SPMP state (spmpcfg, spmpaddr, spmpswitch) feeding the SPMP
// permission checker. Serves CSR reads/writes, legalizes written values and,
// when a write actually changes state, requests a flush of in-flight memory
// accesses and holds the response until the flush is acknowledged.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   csr            : CSR request/response channel (slave side)
//   flush_req_o    : flush request to LSU/fetch, held until flush_ack_i
//   flush_ack_i    : flush done, only observed while flushing
//   spmpcfg_o      : per-entry configuration
//   spmpaddr_o     : per-entry address, PLEN-2 bits
//   spmpswitch_o   : per-entry enables, unimplemented bits zero
// ----------------------------------------------------------------------------
module spmp_csr_regs
   import spmp_csr_regs_pkg::*;
#(
   parameter  int unsigned NrSPMPEntries = 16,
   parameter  int unsigned PLEN          = 56,
   localparam int unsigned NrOut         = (NrSPMPEntries == 0) ? 1 : NrSPMPEntries
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   spmp_csr_regs_if.slave       csr,
   output logic                 flush_req_o,
   input  logic                 flush_ack_i,
   output spmpcfg_t             spmpcfg_o    [NrOut],
   output logic [PLEN-3:0]      spmpaddr_o   [NrOut],
   output logic [XLEN-1:0]      spmpswitch_o
);

   localparam int unsigned     NrCfgWords = (NrSPMPEntries + 7) / 8;
   localparam logic [XLEN-1:0] SwitchMask = switch_mask(NrSPMPEntries);

   spmp_state_e     state_q, state_d;
   logic            req_err;
   logic            changed;
   logic            accept;
   logic            cfg_we, addr_we, switch_we;
   logic [XLEN-1:0] rd_word, wr_word;
   logic [XLEN-1:0] switch_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_err_q;

   // Padded views over all 64 possible entries; unimplemented entries read as
   // zero so that a fixed-width index can select them without range checks.
   wire  [511:0]    cfg_flat;
   wire  [511:0]    legal_flat;
   wire  [PLEN-3:0] addr_pad [64];
   wire  [XLEN-1:0] cfg_rd_word;
   wire  [XLEN-1:0] cfg_wr_word;

   assign accept    = (state_q == ST_IDLE) && csr.req_valid;
   assign cfg_we    = accept && csr.req_we && !req_err && (csr.req_sel == SPMP_SEL_CFG);
   assign addr_we   = accept && csr.req_we && !req_err && (csr.req_sel == SPMP_SEL_ADDR);
   assign switch_we = accept && csr.req_we && !req_err && (csr.req_sel == SPMP_SEL_SWITCH);

   // Per-entry storage with one legalizer each (eight per cfg word). Each
   // legalizer sees its own byte lane of the write data; only the entries of
   // the addressed word commit.
   for (genvar e = 0; e < 64; e++) begin : g_entry
      if (e < NrSPMPEntries) begin : g_live
         logic [7:0]      cfg_q;
         logic [7:0]      legal_byte;
         logic [PLEN-3:0] addr_q;

         spmp_cfg_legalizer u_legalizer (
            .old_byte   (cfg_q),
            .new_byte   (csr.req_wdata[8*(e%8) +: 8]),
            .legal_byte (legal_byte)
         );

         // Commit the legalized cfg byte or the truncated address of this entry.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               cfg_q  <= '0;
               addr_q <= '0;
            end else begin
               if (cfg_we && (csr.req_idx == 6'(e / 8))) begin
                  cfg_q <= legal_byte;
               end
               if (addr_we && (csr.req_idx == 6'(e))) begin
                  addr_q <= csr.req_wdata[PLEN-3:0];
               end
            end
         end

         assign cfg_flat[8*e +: 8]   = cfg_q;
         assign legal_flat[8*e +: 8] = legal_byte;
         assign addr_pad[e]          = addr_q;
         assign spmpcfg_o[e]         = cfg_q;
         assign spmpaddr_o[e]        = addr_q;
      end else begin : g_dead
         assign cfg_flat[8*e +: 8]   = 8'h00;
         assign legal_flat[8*e +: 8] = 8'h00;
         assign addr_pad[e]          = '0;
      end
   end

   if (NrSPMPEntries == 0) begin : g_no_entries
      assign spmpcfg_o[0]  = '0;
      assign spmpaddr_o[0] = '0;
   end

   // Gather the eight byte lanes of the addressed cfg word, both as stored and
   // as they would look after legalizing the write data.
   for (genvar j = 0; j < 8; j++) begin : g_lane
      assign cfg_rd_word[8*j +: 8] = cfg_flat[{csr.req_idx[2:0], 3'(j), 3'b000} +: 8];
      assign cfg_wr_word[8*j +: 8] = legal_flat[{csr.req_idx[2:0], 3'(j), 3'b000} +: 8];
   end

   // Decode the request: error check, current value, post-legalization value
   // and whether committing it would change any state.
   always_comb begin
      req_err = 1'b0;
      rd_word = '0;
      wr_word = '0;
      case (csr.req_sel)
         SPMP_SEL_CFG: begin
            req_err = (32'(csr.req_idx) >= NrCfgWords);
            rd_word = cfg_rd_word;
            wr_word = cfg_wr_word;
         end
         SPMP_SEL_ADDR: begin
            req_err = (32'(csr.req_idx) >= NrSPMPEntries);
            rd_word = {{(XLEN-PLEN+2){1'b0}}, addr_pad[csr.req_idx]};
            wr_word = {{(XLEN-PLEN+2){1'b0}}, csr.req_wdata[PLEN-3:0]};
         end
         SPMP_SEL_SWITCH: begin
            rd_word = switch_q;
            wr_word = csr.req_wdata & SwitchMask;
         end
         default: begin
            req_err = 1'b1;
         end
      endcase
      if (NrSPMPEntries == 0) begin
         req_err = 1'b1;
      end
      changed = (wr_word != rd_word);
   end

   // Entry enables; bits of unimplemented entries are already masked off.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         switch_q <= '0;
      end else if (switch_we) begin
         switch_q <= wr_word;
      end
   end

   // Response payload is captured at acceptance and held through FLUSH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (accept) begin
         rsp_rdata_q <= req_err ? '0 : (csr.req_we ? wr_word : rd_word);
         rsp_err_q   <= req_err;
      end
   end

   // FSM state register; reset aborts any pending flush without a response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs. Only a write that changes state goes
   // through FLUSH; everything else answers one cycle after acceptance.
   always_comb begin
      state_d       = state_q;
      csr.req_ready = 1'b0;
      csr.rsp_valid = 1'b0;
      flush_req_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            csr.req_ready = 1'b1;
            if (csr.req_valid) begin
               state_d = (csr.req_we && !req_err && changed) ? ST_FLUSH : ST_RESP;
            end
         end
         ST_FLUSH: begin
            flush_req_o = 1'b1;
            if (flush_ack_i) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            csr.rsp_valid = 1'b1;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign csr.rsp_rdata = rsp_rdata_q;
   assign csr.rsp_err   = rsp_err_q && (state_q == ST_RESP);
   assign spmpswitch_o  = switch_q;

endmodule

// File: tb/tb_spmp_csr_regs.sv
// ----------------------------------------------------------------------------
// tb_spmp_csr_regs
// Self-checking bench for spmp_csr_regs with 16 entries and PLEN=56. A
// behavioural model of the architectural state tracks every committed write;
// the DUT outputs are compared against it every cycle, and each request's
// handshake, latency and response are checked as it completes.
// ----------------------------------------------------------------------------
module tb_spmp_csr_regs;
   import spmp_csr_regs_pkg::*;

   localparam int N    = 16;
   localparam int NCW  = 2;
   localparam int PLEN = 56;

   logic        clk;
   logic        rst_ni;
   logic        flush_req_o;
   logic        flush_ack_i;
   spmpcfg_t    cfg_out  [N];
   logic [53:0] addr_out [N];
   logic [63:0] switch_out;

   spmp_csr_regs_if bus ();

   spmp_csr_regs #(
      .NrSPMPEntries (N),
      .PLEN          (PLEN)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .csr          (bus),
      .flush_req_o  (flush_req_o),
      .flush_ack_i  (flush_ack_i),
      .spmpcfg_o    (cfg_out),
      .spmpaddr_o   (addr_out),
      .spmpswitch_o (switch_out)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit done   = 0;

   logic [7:0]  m_cfg [N];
   logic [53:0] m_addr [N];
   logic [63:0] m_switch;

   logic [63:0] last_rdata;
   logic        last_err;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_clear();
      for (int e = 0; e < N; e++) begin
         m_cfg[e]  = 8'h00;
         m_addr[e] = '0;
      end
      m_switch = '0;
   endtask

   function automatic logic model_err(input logic [1:0] sel, input logic [5:0] idx);
      case (sel)
         2'd0:    return (int'(idx) >= NCW);
         2'd1:    return (int'(idx) >= N);
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Cfg byte rule: W without R is reserved, S with no permission is reserved;
   // both leave the old byte. Otherwise reserved bits 6:5 read back zero.
   function automatic logic [7:0] model_legal(input logic [7:0] old_b, input logic [7:0] new_b);
      logic r, w, x, s;
      r = new_b[0];
      w = new_b[1];
      x = new_b[2];
      s = new_b[7];
      if (w && !r) return old_b;
      if (s && !x && !w && !r) return old_b;
      return {s, 2'b00, new_b[4:0]};
   endfunction

   function automatic logic [63:0] model_read(input logic [1:0] sel, input logic [5:0] idx);
      logic [63:0] w;
      int e;
      w = '0;
      if (!model_err(sel, idx)) begin
         case (sel)
            2'd0: begin
               for (int j = 0; j < 8; j++) begin
                  e = int'(idx) * 8 + j;
                  w[8*j +: 8] = m_cfg[e[3:0]];
               end
            end
            2'd1:    w = {10'b0, m_addr[idx[3:0]]};
            default: w = m_switch;
         endcase
      end
      return w;
   endfunction

   // Apply one request to the model; commit writes and report the expected
   // response and whether a flush must happen.
   task automatic model_access(input logic we, input logic [1:0] sel, input logic [5:0] idx,
                               input logic [63:0] wdata, output logic [63:0] exp_data,
                               output logic exp_err, output logic exp_flush);
      logic [63:0] old_w, new_w;
      int e;
      exp_err   = model_err(sel, idx);
      old_w     = model_read(sel, idx);
      new_w     = old_w;
      exp_flush = 1'b0;
      if (!exp_err && we) begin
         case (sel)
            2'd0: begin
               for (int j = 0; j < 8; j++) begin
                  e = int'(idx) * 8 + j;
                  new_w[8*j +: 8] = model_legal(m_cfg[e[3:0]], wdata[8*j +: 8]);
                  m_cfg[e[3:0]]   = new_w[8*j +: 8];
               end
            end
            2'd1: begin
               new_w            = {10'b0, wdata[53:0]};
               m_addr[idx[3:0]] = wdata[53:0];
            end
            default: begin
               new_w    = wdata & 64'h0000_0000_0000_FFFF;
               m_switch = new_w;
            end
         endcase
         exp_flush = (new_w != old_w);
      end
      exp_data = exp_err ? 64'h0 : new_w;
   endtask

   // Every cycle the architectural outputs must equal the model state.
   always @(negedge clk) begin
      if (!done) begin
         int    bad;
         logic [7:0] b;
         bad = -1;
         for (int e = 0; e < N; e++) begin
            b = cfg_out[e];
            if ((b !== m_cfg[e] || addr_out[e] !== m_addr[e]) && bad < 0) bad = e;
         end
         checks++;
         if (bad >= 0 || switch_out !== m_switch) begin
            errors++;
            if (bad >= 0) begin
               b = cfg_out[bad];
               $display("[TB] FAIL arch_state entry %0d: cfg got 0x%0h expected 0x%0h, addr got 0x%0h expected 0x%0h",
                        bad, b, m_cfg[bad], addr_out[bad], m_addr[bad]);
            end else begin
               $display("[TB] FAIL arch_state switch: got 0x%0h expected 0x%0h", switch_out, m_switch);
            end
         end
      end
   end

   // Drive one request and check handshake, flush behaviour, latency and
   // response. Ack noise is applied while idle, where it must be ignored.
   task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [5:0] idx,
                                input logic [63:0] wdata, input int ack_delay);
      logic [63:0] exp_data;
      logic        exp_err, exp_flush;
      @(negedge clk);
      checkOutput("rsp_single_cycle", bus.rsp_valid, 1'b0);
      checkOutput("ready_idle", bus.req_ready, 1'b1);
      flush_ack_i     = 1'($urandom_range(0, 1));
      bus.req_valid   = 1'b1;
      bus.req_we      = we;
      bus.req_sel     = spmp_sel_e'(sel);
      bus.req_idx     = idx;
      bus.req_wdata   = wdata;
      @(posedge clk);
      #1;
      bus.req_valid   = 1'b0;
      flush_ack_i     = 1'b0;
      model_access(we, sel, idx, wdata, exp_data, exp_err, exp_flush);
      @(negedge clk);
      if (exp_flush) begin
         checkOutput("flush_rise", flush_req_o, 1'b1);
         checkOutput("ready_flush", bus.req_ready, 1'b0);
         checkOutput("rsp_in_flush", bus.rsp_valid, 1'b0);
         for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            checkOutput("flush_hold", flush_req_o, 1'b1);
            checkOutput("ready_flush", bus.req_ready, 1'b0);
            checkOutput("rsp_in_flush", bus.rsp_valid, 1'b0);
         end
         flush_ack_i = 1'b1;
         @(negedge clk);
         flush_ack_i = 1'b0;
      end
      checkOutput("rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("rsp_rdata", bus.rsp_rdata, exp_data);
      checkOutput("rsp_err", bus.rsp_err, exp_err);
      checkOutput("flush_low_rsp", flush_req_o, 1'b0);
      checkOutput("ready_rsp", bus.req_ready, 1'b0);
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
   endtask

   // Runaway guard.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic        we;
      logic [1:0]  sel;
      logic [5:0]  idx;
      logic [63:0] wdata;
      int          r;

      rst_ni        = 1'b0;
      flush_ack_i   = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_sel   = SPMP_SEL_CFG;
      bus.req_idx   = '0;
      bus.req_wdata = '0;
      model_clear();
      repeat (2) @(negedge clk);
      checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("reset_rsp_err", bus.rsp_err, 1'b0);
      checkOutput("reset_rsp_rdata", bus.rsp_rdata, 64'h0);
      checkOutput("reset_flush", flush_req_o, 1'b0);
      rst_ni = 1'b1;

      // Reset state readback.
      applyStimulus(1'b0, 2'd0, 6'd0, 64'h0, 0);
      checkOutput("lit_read_cfg0", last_rdata, 64'h0);
      checkOutput("lit_switch_reset", switch_out, 64'h0);

      // Write two legal cfg bytes, ack three cycles after the flush starts.
      applyStimulus(1'b1, 2'd0, 6'd0, 64'h0000_0000_0000_0F8D, 3);
      checkOutput("lit_cfg0", 64'(cfg_out[0]), 64'h8D);
      checkOutput("lit_cfg1", 64'(cfg_out[1]), 64'h0F);
      checkOutput("lit_model_cfg0", 64'(m_cfg[0]), 64'h8D);
      checkOutput("lit_wr_rdata", last_rdata, 64'h0F8D);

      // Reserved encodings keep the old byte: no change, no flush.
      applyStimulus(1'b1, 2'd0, 6'd0, 64'h0000_0000_0000_0F02, 2);
      checkOutput("lit_warl_wr01", last_rdata, 64'h0F8D);
      applyStimulus(1'b1, 2'd0, 6'd0, 64'h0000_0000_0000_0F80, 2);
      checkOutput("lit_warl_s_none", last_rdata, 64'h0F8D);
      checkOutput("lit_cfg0_kept", 64'(cfg_out[0]), 64'h8D);

      // Switch bits above the entry count are dropped.
      applyStimulus(1'b1, 2'd2, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      checkOutput("lit_switch", switch_out, 64'h0000_0000_0000_FFFF);

      // Out-of-range address entry.
      applyStimulus(1'b0, 2'd1, 6'd16, 64'h0, 0);
      checkOutput("lit_addr16_err", 64'(last_err), 64'h1);
      checkOutput("lit_addr16_rdata", last_rdata, 64'h0);

      // Address truncated to PLEN-2 bits, ack in the first flush cycle.
      applyStimulus(1'b1, 2'd1, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      checkOutput("lit_addr3", 64'(addr_out[3]), 64'h003F_FFFF_FFFF_FFFF);
      checkOutput("lit_addr3_rdata", last_rdata, 64'h003F_FFFF_FFFF_FFFF);
      applyStimulus(1'b0, 2'd1, 6'd3, 64'h0, 0);
      checkOutput("lit_addr3_read", last_rdata, 64'h003F_FFFF_FFFF_FFFF);

      // Reset in the middle of a flush.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_sel   = SPMP_SEL_CFG;
      bus.req_idx   = 6'd0;
      bus.req_wdata = 64'h0000_0000_0000_0F0F;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      begin
         logic [63:0] d;
         logic        e, f;
         model_access(1'b1, 2'd0, 6'd0, 64'h0F0F, d, e, f);
      end
      @(negedge clk);
      checkOutput("rst_mid_flush_pre", flush_req_o, 1'b1);
      #1;
      rst_ni = 1'b0;
      model_clear();
      #1;
      checkOutput("rst_flush_drop", flush_req_o, 1'b0);
      checkOutput("rst_no_rsp", bus.rsp_valid, 1'b0);
      checkOutput("rst_switch_clear", switch_out, 64'h0);
      checkOutput("rst_cfg0_clear", 64'(cfg_out[0]), 64'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_no_rsp_hold", bus.rsp_valid, 1'b0);
         checkOutput("rst_no_flush_hold", flush_req_o, 1'b0);
      end
      rst_ni = 1'b1;
      applyStimulus(1'b0, 2'd0, 6'd0, 64'h0, 0);
      checkOutput("lit_post_reset_read", last_rdata, 64'h0);

      // Randomized traffic, including unchanged rewrites and illegal targets.
      for (int n = 0; n < 120; n++) begin
         r  = $urandom_range(0, 9);
         we = ($urandom_range(0, 2) != 0);
         if (r < 4) begin
            sel = 2'd0;
            idx = 6'($urandom_range(0, 2));
         end else if (r < 7) begin
            sel = 2'd1;
            idx = 6'($urandom_range(0, 17));
         end else if (r < 9) begin
            sel = 2'd2;
            idx = 6'($urandom_range(0, 63));
         end else begin
            sel = 2'd3;
            idx = 6'($urandom_range(0, 63));
         end
         wdata = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            wdata = model_read(sel, idx);
         end
         applyStimulus(we, sel, idx, wdata, $urandom_range(0, 3));
      end

      @(negedge clk);
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
